// File: rtl/rca64_seq_ctrl_if.sv
// Handshake and data bundle for the sliced 64-bit add/subtract sequencer.
// The master side presents operands and consumes results; the slave side is the sequencer.
interface rca64_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        sub;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] s;
  logic        c_out;
  logic        ovf;

  modport master (
    output in_valid, a, b, sub, c_in, out_ready,
    input  in_ready, out_valid, s, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, c_in, out_ready,
    output in_ready, out_valid, s, c_out, ovf
  );
endinterface

// File: rtl/rca64_seq_ctrl.sv
// 64-bit add/subtract built from one SLICE_W-bit ripple slice reused over 64/SLICE_W cycles.
// A registered carry links consecutive slices; results are held until the consumer accepts them.
module rca64_seq_ctrl #(
  parameter int unsigned SLICE_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rca64_seq_ctrl_if.slave  bus
);
  localparam int unsigned N  = 64 / SLICE_W;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [KW-1:0]       r_k;
  logic                r_cy;
  logic [63:0]         r_a;
  logic [63:0]         r_b;
  logic [63:0]         r_s;
  logic                r_cout;
  logic                r_ovf;

  logic                w_accept;
  logic                w_last;
  logic [5:0]          w_lo;
  logic [SLICE_W-1:0]  w_a_sl;
  logic [SLICE_W-1:0]  w_b_sl;
  logic [SLICE_W-1:0]  w_sum;
  logic                w_c_msb;
  logic                w_c_next;

  assign w_lo   = 6'(r_k * SLICE_W);
  assign w_a_sl = r_a[w_lo +: SLICE_W];
  assign w_b_sl = r_b[w_lo +: SLICE_W];
  assign w_last = (r_k == KW'(N - 1));

  // Plain full-adder chain; the carry into the slice MSB is kept for overflow on the last slice.
  always_comb begin
    logic cc;
    cc       = r_cy;
    w_sum    = '0;
    w_c_msb  = 1'b0;
    for (int unsigned i = 0; i < SLICE_W; i++) begin
      if (i == SLICE_W - 1) w_c_msb = cc;
      w_sum[i] = w_a_sl[i] ^ w_b_sl[i] ^ cc;
      cc       = (w_a_sl[i] & w_b_sl[i]) | (cc & (w_a_sl[i] ^ w_b_sl[i]));
    end
    w_c_next = cc;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k    <= '0;
      r_cy   <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_s    <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_a  <= bus.a;
      r_b  <= bus.sub ? ~bus.b : bus.b;
      r_cy <= bus.sub | bus.c_in;
      r_k  <= '0;
    end else if (r_state == RUN) begin
      r_s[w_lo +: SLICE_W] <= w_sum;
      r_cy                 <= w_c_next;
      if (w_last) begin
        r_cout <= w_c_next;
        r_ovf  <= w_c_msb ^ w_c_next;
      end else begin
        r_k <= r_k + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.s         = r_s;
  assign bus.c_out     = r_cout;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_rca64_seq_ctrl.sv
// Drives three sequencer instances (SLICE_W 8, 16, 32) in lockstep and checks each against
// an arithmetic reference, including latency, backpressure and mid-operation reset.
module tb_rca64_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, sub, c_in, out_ready;
  logic [63:0] a, b;

  logic        ir [3];
  logic        ov [3];
  logic        co [3];
  logic        vf [3];
  logic [63:0] so [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rca64_seq_ctrl_if bus ();
    assign bus.in_valid  = in_valid;
    assign bus.a         = a;
    assign bus.b         = b;
    assign bus.sub       = sub;
    assign bus.c_in      = c_in;
    assign bus.out_ready = out_ready;
    assign ir[g] = bus.in_ready;
    assign ov[g] = bus.out_valid;
    assign co[g] = bus.c_out;
    assign vf[g] = bus.ovf;
    assign so[g] = bus.s;

    rca64_seq_ctrl #(.SLICE_W(8 << g)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[w%0d]: observed %h expected %h", tag, 8 << d, obs, exp);
    end
  endtask

  task automatic model(input logic [63:0] ta, input logic [63:0] tb_, input logic tsub,
                       input logic tcin, output logic [63:0] es, output logic ec, output logic eo);
    logic [64:0] t;
    if (tsub) begin
      es = ta - tb_;
      ec = (ta >= tb_);
      eo = (ta[63] != tb_[63]) && (es[63] != ta[63]);
    end else begin
      t  = {1'b0, ta} + {1'b0, tb_} + {64'd0, tcin};
      es = t[63:0];
      ec = t[64];
      eo = (ta[63] == tb_[63]) && (es[63] != ta[63]);
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_in_ready"},  d, 64'(ir[d]), 64'd1);
      chk({tag, "_out_valid"}, d, 64'(ov[d]), 64'd0);
      chk({tag, "_s"},         d, so[d],      64'd0);
      chk({tag, "_c_out"},     d, 64'(co[d]), 64'd0);
      chk({tag, "_ovf"},       d, 64'(vf[d]), 64'd0);
    end
  endtask

  // Accepts one operation on all instances, waits for each result and checks it; leaves them in DONE.
  task automatic exec(input string tag, input logic [63:0] ta, input logic [63:0] tb_,
                      input logic tsub, input logic tcin);
    logic [63:0] es;
    logic        ec, eo;
    int          lat [3];
    model(ta, tb_, tsub, tcin, es, ec, eo);
    for (int d = 0; d < 3; d++) chk({tag, "_ready_pre"}, d, 64'(ir[d]), 64'd1);
    a = ta; b = tb_; sub = tsub; c_in = tcin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = '0; b = '0; sub = 1'b0; c_in = 1'b0;
    for (int d = 0; d < 3; d++) lat[d] = -1;
    for (int cyc = 0; cyc <= 20; cyc++) begin
      for (int d = 0; d < 3; d++)
        if (ov[d] === 1'b1 && lat[d] < 0) lat[d] = cyc;
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      @(posedge clk); #1;
    end
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_latency"}, d, 64'(lat[d]), 64'(64 / (8 << d)));
      chk({tag, "_s"},       d, so[d],       es);
      chk({tag, "_c_out"},   d, 64'(co[d]),  64'(ec));
      chk({tag, "_ovf"},     d, 64'(vf[d]),  64'(eo));
    end
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_ack_valid"}, d, 64'(ov[d]), 64'd0);
      chk({tag, "_ack_ready"}, d, 64'(ir[d]), 64'd1);
    end
  endtask

  initial begin
    logic [63:0] ra, rb, es;
    logic        ec, eo;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; c_in = 1'b0;
    #12;
    check_reset_values("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    exec("ripple",   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0); ack("ripple");
    exec("sub_neg",  64'd5, 64'd7, 1'b1, 1'b0);                   ack("sub_neg");
    exec("sub_pos",  64'd7, 64'd5, 1'b1, 1'b1);                   ack("sub_pos");
    exec("ovf",      64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0); ack("ovf");
    exec("cin_span", 64'h0000_0000_FFFF_FFFF, 64'd0, 1'b0, 1'b1); ack("cin_span");
    exec("sub_min",  64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0); ack("sub_min");

    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      exec("rand", ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)));
      ack("rand");
    end

    // Backpressure: result must hold and new operands must be refused while DONE.
    exec("bp", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1);
    model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1, es, ec, eo);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom};
      sub = 1'($urandom_range(1)); c_in = 1'b1;
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        chk("bp_hold_s",     d, so[d],      es);
        chk("bp_hold_c_out", d, 64'(co[d]), 64'(ec));
        chk("bp_hold_ovf",   d, 64'(vf[d]), 64'(eo));
        chk("bp_in_ready",   d, 64'(ir[d]), 64'd0);
        chk("bp_out_valid",  d, 64'(ov[d]), 64'd1);
      end
    end
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; c_in = 1'b0;
    ack("bp");
    exec("after_bp", 64'd100, 64'd23, 1'b1, 1'b0); ack("after_bp");

    // Reset two cycles into an operation, then a fresh add.
    a = 64'hFFFF_0000_FFFF_0000; b = 64'h0F0F_0F0F_0F0F_0F0F; sub = 1'b0; c_in = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    exec("post_rst", 64'd3, 64'd4, 1'b0, 1'b0); ack("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
